// File: rtl/piso_tx.sv
// piso_tx: parallel-in serial-out transmitter with ready/load handshake and gapless word streaming
module piso_tx #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             load,
    output logic             ready,
    output logic             out,
    output logic             valid,
    output logic             last
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           r_state, w_state_nx;
    logic [WIDTH-1:0] r_shreg, w_shreg_nx, w_shifted;
    logic [CW-1:0]    r_cnt, w_cnt_nx;
    logic             w_last_bit, w_accept;

    // outputs and handshake decoded purely from registers
    always_comb begin
        w_last_bit = (r_state == SHIFT) && (r_cnt == CNT_MAX);
        ready      = (r_state == IDLE) || w_last_bit;
        valid      = (r_state == SHIFT);
        last       = w_last_bit;
        out        = valid && (MSB_FIRST ? r_shreg[WIDTH-1] : r_shreg[0]);
        w_shifted  = MSB_FIRST ? {r_shreg[WIDTH-2:0], 1'b0} : {1'b0, r_shreg[WIDTH-1:1]};
        w_accept   = load && ready;
    end

    // next state: accept reloads, otherwise shift; the last bit without accept returns to IDLE
    always_comb begin
        w_state_nx = r_state;
        w_shreg_nx = r_shreg;
        w_cnt_nx   = r_cnt;
        if (w_accept) begin
            w_state_nx = SHIFT;
            w_shreg_nx = din;
            w_cnt_nx   = '0;
        end else if (r_state == SHIFT) begin
            w_shreg_nx = w_shifted;
            w_cnt_nx   = w_last_bit ? '0 : r_cnt + 1'b1;
            w_state_nx = w_last_bit ? IDLE : SHIFT;
        end
    end

    // state registers; reset aborts any word in flight and outranks load
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_shreg <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_shreg <= w_shreg_nx;
            r_cnt   <= w_cnt_nx;
        end
    end
endmodule

// File: tb/tb_piso_tx.sv
// tb_piso_tx: table-driven check of MSB- and LSB-first transmitters plus a downstream chain loopback
module tb_piso_tx;
    typedef struct {
        logic       rst;
        logic       load;
        logic [3:0] din;
        logic       o;
        logic       v;
        logic       l;
        logic       r;
        logic       lo;
    } vec_t;

    logic       clk  = 1'b0;
    logic       rst  = 1'b1;
    logic       load = 1'b1;
    logic [3:0] din  = 4'hF;
    logic       rdy_m, out_m, val_m, last_m;
    logic       rdy_l, out_l, val_l, last_l;
    logic [3:0] chain;
    logic [3:0] lb;
    int         checks = 0;
    int         failures = 0;
    vec_t       q[$];

    always #5 clk = ~clk;

    piso_tx #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst(rst), .din(din), .load(load),
        .ready(rdy_m), .out(out_m), .valid(val_m), .last(last_m)
    );

    piso_tx #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst(rst), .din(din), .load(load),
        .ready(rdy_l), .out(out_l), .valid(val_l), .last(last_l)
    );

    // 4-stage serial chain fed by the MSB-first stream
    always_ff @(posedge clk) chain <= {chain[2:0], out_m};

    task automatic chk(input string n, input logic a, input logic e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%b required=%b", n, a, e);
        end
    endtask

    task automatic add(input logic rs, input logic ld, input logic [3:0] d,
                       input logic o, input logic v, input logic l, input logic r, input logic lo);
        q.push_back('{rs, ld, d, o, v, l, r, lo});
    endtask

    initial begin
        // second reset cycle with load high, then idle
        add(1, 1, 4'hF, 0, 0, 0, 1, 0);
        add(0, 0, 4'h0, 0, 0, 0, 1, 0);
        // single word 1011
        add(0, 1, 4'b1011, 0, 0, 0, 1, 0);
        add(0, 0, 4'h0, 1, 1, 0, 0, 1);
        add(0, 0, 4'h0, 0, 1, 0, 0, 1);
        add(0, 0, 4'h0, 1, 1, 0, 0, 0);
        add(0, 0, 4'h0, 1, 1, 1, 1, 1);
        add(0, 0, 4'h0, 0, 0, 0, 1, 0);
        // back-to-back 1011 then 0110
        add(0, 1, 4'b1011, 0, 0, 0, 1, 0);
        add(0, 0, 4'h0, 1, 1, 0, 0, 1);
        add(0, 0, 4'h0, 0, 1, 0, 0, 1);
        add(0, 0, 4'h0, 1, 1, 0, 0, 0);
        add(0, 1, 4'b0110, 1, 1, 1, 1, 1);
        add(0, 0, 4'h0, 0, 1, 0, 0, 0);
        add(0, 0, 4'h0, 1, 1, 0, 0, 1);
        add(0, 0, 4'h0, 1, 1, 0, 0, 1);
        add(0, 0, 4'h0, 0, 1, 1, 1, 0);
        add(0, 0, 4'h0, 0, 0, 0, 1, 0);
        // loads while busy are ignored
        add(0, 1, 4'b1011, 0, 0, 0, 1, 0);
        add(0, 1, 4'b0000, 1, 1, 0, 0, 1);
        add(0, 1, 4'b0000, 0, 1, 0, 0, 1);
        add(0, 0, 4'h0, 1, 1, 0, 0, 0);
        add(0, 0, 4'h0, 1, 1, 1, 1, 1);
        add(0, 0, 4'h0, 0, 0, 0, 1, 0);
        // reset mid-word
        add(0, 1, 4'b1011, 0, 0, 0, 1, 0);
        add(0, 0, 4'h0, 1, 1, 0, 0, 1);
        add(1, 0, 4'h0, 0, 1, 0, 0, 1);
        add(0, 0, 4'h0, 0, 0, 0, 1, 0);
        add(0, 0, 4'h0, 0, 0, 0, 1, 0);

        @(posedge clk); #1;
        foreach (q[i]) begin
            rst  = q[i].rst;
            load = q[i].load;
            din  = q[i].din;
            #1;
            chk($sformatf("row%0d out", i),       out_m, q[i].o);
            chk($sformatf("row%0d valid", i),     val_m, q[i].v);
            chk($sformatf("row%0d last", i),      last_m, q[i].l);
            chk($sformatf("row%0d ready", i),     rdy_m, q[i].r);
            chk($sformatf("row%0d lsb_out", i),   out_l, q[i].lo);
            chk($sformatf("row%0d lsb_valid", i), val_l, q[i].v);
            @(posedge clk); #1;
        end

        // loopback through the 4-stage chain: bits reappear in t+5..t+8
        lb   = 4'b1011;
        load = 1'b1;
        din  = lb;
        @(posedge clk); #1;
        load = 1'b0;
        din  = 4'h0;
        for (int k = 1; k <= 8; k++) begin
            if (k >= 5) chk($sformatf("chain t+%0d", k), chain[3], lb[8-k]);
            @(posedge clk); #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
